// File: rtl/mod_pkg.sv
// Shared encodings for the symbol transmitter: modulation modes, FSM states, modulator.
// Define MOD_SYMBOL_TX_PSK_EN to enable PSK; otherwise mode 11 falls back to baseband.
package mod_pkg;

  localparam logic [1:0] MODE_BB  = 2'b00;
  localparam logic [1:0] MODE_ASK = 2'b01;
  localparam logic [1:0] MODE_FSK = 2'b10;
  localparam logic [1:0] MODE_PSK = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ALIGN = 2'b01;
  localparam logic [1:0] ST_SHIFT = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  function automatic logic modulate(input logic [1:0] m, input logic b,
                                    input logic c0, input logic c1);
    case (m)
      MODE_ASK: return b & c0;
      MODE_FSK: return b ? c1 : c0;
`ifdef MOD_SYMBOL_TX_PSK_EN
      MODE_PSK: return c0 ^ b;
`endif
      default:  return b;
    endcase
  endfunction

endpackage

// File: rtl/mod_symbol_tx_sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus a one-clk rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Pulse is consumed by the third clk edge after the input rises.
  assign pulse = s2 & ~s3;

endmodule

// File: rtl/mod_symbol_tx.sv
// Serial symbol transmitter: MSB-first word shifted at the symbol rate, with BB/ASK/FSK/PSK output.
// PSK is present only when MOD_SYMBOL_TX_PSK_EN is defined.
module mod_symbol_tx
  import mod_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CAR0_HALF = 2500,
  parameter int CAR1_HALF = 1250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sym_clk,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              bit_out,
  output logic              mod_out,
  output logic              busy,
  output logic              done
);

  localparam int C0W  = (CAR0_HALF > 1) ? $clog2(CAR0_HALF) : 1;
  localparam int C1W  = (CAR1_HALF > 1) ? $clog2(CAR1_HALF) : 1;
  localparam int CNTW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic              sym_edge;
  logic [C0W-1:0]    cnt0;
  logic [C1W-1:0]    cnt1;
  logic              car0, car1;
  logic [1:0]        state;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] sh;
  logic [CNTW-1:0]   bit_cnt;

  sync_edge u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (sym_clk),
    .pulse (sym_edge)
  );

  // Carriers free-run from reset, independent of the transfer state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      car0 <= 1'b0;
    end else if (cnt0 == C0W'(CAR0_HALF - 1)) begin
      cnt0 <= '0;
      car0 <= ~car0;
    end else begin
      cnt0 <= cnt0 + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt1 <= '0;
      car1 <= 1'b0;
    end else if (cnt1 == C1W'(CAR1_HALF - 1)) begin
      cnt1 <= '0;
      car1 <= ~car1;
    end else begin
      cnt1 <= cnt1 + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_BB;
      sh      <= '0;
      bit_cnt <= '0;
      bit_out <= 1'b0;
      mod_out <= 1'b0;
    end else begin
      mod_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (data_valid) begin
            sh     <= data_in;
            mode_q <= mode;
            state  <= ST_ALIGN;
          end
        end
        // A coincident sym_edge at accept is ignored: ALIGN only sees later edges.
        ST_ALIGN: begin
          if (sym_edge) begin
            bit_out <= sh[DATA_W-1];
            sh      <= sh << 1;
            bit_cnt <= CNTW'(DATA_W - 1);
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          mod_out <= modulate(mode_q, bit_out, car0, car1);
          if (sym_edge) begin
            if (bit_cnt != '0) begin
              bit_out <= sh[DATA_W-1];
              sh      <= sh << 1;
              bit_cnt <= bit_cnt - 1'b1;
            end else begin
              bit_out <= 1'b0;
              mod_out <= 1'b0;
              state   <= ST_DONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign data_ready = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_mod_symbol_tx.sv
// Directed self-checking bench for mod_symbol_tx (CAR0_HALF=4, CAR1_HALF=2, sym_clk period 64 clk).
module tb_mod_symbol_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sym_clk = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready, bit_out, mod_out, busy, done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic hs_watch = 1'b0;
  logic hs_bad = 1'b0;

  mod_symbol_tx #(.DATA_W(8), .CAR0_HALF(4), .CAR1_HALF(2)) dut (
    .clk(clk), .rst(rst), .sym_clk(sym_clk), .mode(mode), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .bit_out(bit_out),
    .mod_out(mod_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  initial begin
    #2;
    forever #320 sym_clk = ~sym_clk;
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (hs_watch && data_ready !== 1'b0) hs_bad <= 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Accept a word away from any symbol edge; the mode input is then scrambled.
  task automatic send(input logic [7:0] d, input logic [1:0] m);
    @(posedge sym_clk);
    repeat (10) @(posedge clk);
    #1 data_in = d; mode = m; data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0; mode = ~m;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after 2000 cycles, want 0", busy);
    end
  endtask

  task automatic get_word(output logic [7:0] w);
    w = '0;
    for (int i = 7; i >= 0; i--) begin
      @(posedge sym_clk);
      repeat (20) @(posedge clk);
      #1 w[i] = bit_out;
    end
  endtask

  task automatic capture(output logic [40:0] s);
    s = '0;
    @(posedge sym_clk);
    repeat (11) @(posedge clk);
    for (int j = 0; j <= 40; j++) begin
      @(negedge clk);
      s[j] = mod_out;
    end
  endtask

  function automatic int toggles(input logic [40:0] s);
    int t = 0;
    for (int j = 1; j <= 40; j++) if (s[j] != s[j-1]) t++;
    return t;
  endfunction

  function automatic bit gaps_ok(input logic [40:0] s, input int g);
    int last = -1;
    for (int j = 1; j <= 40; j++) begin
      if (s[j] != s[j-1]) begin
        if (last >= 0 && (j - last) != g) return 1'b0;
        last = j;
      end
    end
    return 1'b1;
  endfunction

  task automatic test_reset();
    logic [7:0] w;
    int d0;
    #1;
    checks++;
    if ({bit_out, mod_out, busy, done, data_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL por_state: bo/mo/busy/done/rdy=%b want 00001",
               {bit_out, mod_out, busy, done, data_ready});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send(8'hFF, 2'b00);
    @(posedge sym_clk);
    repeat (23) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bit_out, mod_out, busy} !== 3'b111) begin
      errors++;
      $display("FAIL pre_reset_shift: bo/mo/busy=%b want 111", {bit_out, mod_out, busy});
    end
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bit_out, mod_out, busy, data_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL mid_reset: bo/mo/busy/rdy=%b want 0001", {bit_out, mod_out, busy, data_ready});
    end
    @(negedge clk) rst = 1'b0;
    repeat (700) @(posedge clk);
    @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: done pulses=%0d busy=%b want 0 and 0", done_cnt - d0, busy);
    end
    send(8'h5A, 2'b00);
    get_word(w);
    checks++;
    if (w !== 8'h5A) begin
      errors++;
      $display("FAIL reset_fresh_word: got %h want 5a", w);
    end
    wait_idle();
  endtask

  task automatic test_baseband();
    logic [7:0] d = 8'hA5;
    logic prev = 1'b0;
    int d0 = done_cnt;
    send(d, 2'b00);
    for (int i = 7; i >= 0; i--) begin
      @(posedge sym_clk);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bit_out !== prev) begin
        errors++;
        $display("FAIL bb_hold bit%0d: got %b want %b", i, bit_out, prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bit_out !== d[i]) begin
        errors++;
        $display("FAIL bb_bit bit%0d: got %b want %b", i, bit_out, d[i]);
      end
      prev = d[i];
    end
    @(posedge sym_clk);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({done, busy} !== 2'b01) begin
      errors++;
      $display("FAIL bb_pre_done: done/busy=%b want 01", {done, busy});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({done, bit_out, busy} !== 3'b101) begin
      errors++;
      $display("FAIL bb_done: done/bo/busy=%b want 101", {done, bit_out, busy});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({done, busy, data_ready} !== 3'b001) begin
      errors++;
      $display("FAIL bb_post_done: done/busy/rdy=%b want 001", {done, busy, data_ready});
    end
    @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL bb_done_count: got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_ask_fsk();
    logic [40:0] s;
    logic [7:0] d;
    int t;
    d = 8'hF0;
    send(d, 2'b01);
    for (int i = 7; i >= 0; i--) begin
      capture(s);
      t = toggles(s);
      checks++;
      if (d[i] ? (t != 10 || !gaps_ok(s, 4)) : (s !== 41'd0)) begin
        errors++;
        $display("FAIL ask_bit%0d: toggles=%0d gaps4=%b want %0d", i, t, gaps_ok(s, 4), d[i] ? 10 : 0);
      end
    end
    wait_idle();
    d = 8'h0F;
    send(d, 2'b10);
    for (int i = 7; i >= 0; i--) begin
      capture(s);
      t = toggles(s);
      checks++;
      if (d[i] ? (t != 20 || !gaps_ok(s, 2)) : (t != 10 || !gaps_ok(s, 4))) begin
        errors++;
        $display("FAIL fsk_bit%0d: toggles=%0d want %0d", i, t, d[i] ? 20 : 10);
      end
    end
    wait_idle();
  endtask

  task automatic test_psk();
    logic [40:0] s [8];
    send(8'h55, 2'b11);
    for (int k = 0; k < 8; k++) capture(s[k]);
    for (int k = 1; k < 8; k += 2) begin
      checks++;
`ifdef MOD_SYMBOL_TX_PSK_EN
      if (s[k] !== ~s[k-1] || toggles(s[k-1]) != 10) begin
        errors++;
        $display("FAIL psk_sym%0d: got %h want %h (inverse of car0 window)", k, s[k], ~s[k-1]);
      end
`else
      if (s[k-1] !== 41'd0 || s[k] !== {41{1'b1}}) begin
        errors++;
        $display("FAIL psk_as_bb_sym%0d: got %h/%h want 0/all-ones", k, s[k-1], s[k]);
      end
`endif
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    logic seen = 1'b0;
    send(8'h81, 2'b00);
    #1 data_in = 8'h3C; mode = 2'b00; data_valid = 1'b1;
    hs_bad = 1'b0;
    hs_watch = 1'b1;
    get_word(w);
    checks++;
    if (w !== 8'h81) begin
      errors++;
      $display("FAIL hs_first_word: got %h want 81", w);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; break; end
    end
    hs_watch = 1'b0;
    checks++;
    if (!seen || hs_bad) begin
      errors++;
      $display("FAIL hs_busy_ready: done_seen=%b ready_leak=%b want 1 and 0", seen, hs_bad);
    end
    @(negedge clk);
    checks++;
    if ({data_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL hs_after_done: rdy/busy=%b want 10", {data_ready, busy});
    end
    @(posedge clk);
    #1 data_valid = 1'b0;
    checks++;
    if ({data_ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL hs_accept: rdy/busy=%b want 01", {data_ready, busy});
    end
    get_word(w);
    checks++;
    if (w !== 8'h3C) begin
      errors++;
      $display("FAIL hs_second_word: got %h want 3c", w);
    end
    wait_idle();
  endtask

  task automatic test_edge_coincide();
    @(posedge sym_clk);
    repeat (2) @(posedge clk);
    #1 data_in = 8'h80; mode = 2'b00; data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    checks++;
    if ({busy, bit_out} !== 2'b10) begin
      errors++;
      $display("FAIL coin_accept: busy/bo=%b want 10", {busy, bit_out});
    end
    repeat (63) @(posedge clk);
    #1;
    checks++;
    if (bit_out !== 1'b0) begin
      errors++;
      $display("FAIL coin_early: bo=%b want 0 at 63 clk", bit_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bit_out !== 1'b1) begin
      errors++;
      $display("FAIL coin_first_bit: bo=%b want 1 at 64 clk", bit_out);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_baseband();
    test_ask_fsk();
    test_psk();
    test_back_to_back();
    test_edge_coincide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_symbol_tx.md
MOD_SYMBOL_TX -- requirements
Module: mod_symbol_tx

Interface
REQ-001 Parameter DATA_W, default 8: bits per transmitted word.
REQ-002 Parameter CAR0_HALF, default 2500: half-period of carrier 0 in clk cycles (10 kHz at 50 MHz).
REQ-003 Parameter CAR1_HALF, default 1250: half-period of carrier 1 in clk cycles (20 kHz at 50 MHz).
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- sym_clk  in  1  2 kHz symbol-rate clock from the frequency divider.
- mode  in  2  modulation select: 00 baseband, 01 ASK, 10 FSK, 11 PSK.
- data_in  in  DATA_W  word to transmit.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  block accepts a word this cycle.
- bit_out  out  1  current symbol bit (baseband).
- mod_out  out  1  modulated output.
- busy  out  1  a transfer is in progress.
- done  out  1  one-cycle pulse at end of transfer.

Function
REQ-005 sym_clk SHALL pass through a 2-flop synchronizer, then a rising-edge detector; sym_edge SHALL pulse for 1 clk, 3 clk after a sym_clk rising edge.
REQ-006 The FSM SHALL have states IDLE, ALIGN, SHIFT and DONE.
REQ-007 IDLE: data_ready=1 and busy=0; when data_valid&data_ready, the block SHALL latch data_in and mode, then go to ALIGN.
REQ-008 data_ready SHALL be 0 in every state except IDLE; data_valid outside IDLE SHALL be ignored.
REQ-009 ALIGN: on sym_edge, bit_out SHALL take data MSB, bit_cnt SHALL load DATA_W-1, and the FSM SHALL go to SHIFT.
REQ-010 A sym_edge in the same cycle as the accept SHALL NOT start transmission; ALIGN waits for the next sym_edge.
REQ-011 SHIFT: on each sym_edge with bit_cnt>0, bit_out SHALL take the next lower bit and bit_cnt SHALL decrement.
REQ-012 SHIFT: on sym_edge with bit_cnt=0, the FSM SHALL go to DONE; every bit therefore lasts exactly one symbol period.
REQ-013 DONE: done=1 for exactly one cycle, bit_out=0, then IDLE; the word following a transfer SHALL be acceptable in the cycle after DONE.
REQ-014 busy SHALL be 1 in ALIGN, SHIFT and DONE.
REQ-015 Carrier counters car0 and car1 SHALL run freely from reset and toggle square waves every CAR0_HALF and CAR1_HALF clk cycles; counter width = $clog2 of the half-period.
REQ-016 In SHIFT, mod_out SHALL be registered and equal to:
- bit_out for mode 00;
- bit_out & car0 for 01;
- bit_out ? car1 : car0 for 10;
- car0 ^ bit_out for 11.
REQ-017 Outside SHIFT, mod_out SHALL be 0.
REQ-018 The latched mode SHALL NOT change mid-word; changes on the mode input apply to the next accepted word.

Reset
REQ-019 rst SHALL asynchronously force:
- state to IDLE;
- bit_out, mod_out, done and busy to 0;
- carriers, counters and synchronizer flops to 0;
- data_ready to 1.
REQ-020 Reset asserted mid-transfer SHALL abort the word; the first accept after release SHALL start a fresh word.

Configuration
REQ-021 Macro MOD_SYMBOL_TX_PSK_EN compiles in PSK; without it, mode 11 SHALL behave as mode 00 (baseband).

Structure
REQ-022 Package mod_pkg SHALL hold the mode encodings (MODE_BB, MODE_ASK, MODE_FSK, MODE_PSK) and the FSM state encoding.
REQ-023 Sub-module sync_edge (2-flop synchronizer plus rising-edge pulse) SHALL be instantiated for sym_clk.

Verification (bench: DATA_W=8, CAR0_HALF=4, CAR1_HALF=2, sym_clk period 64 clk)
REQ-024 Reset: assert rst mid-SHIFT -> same cycle bit_out=0, mod_out=0, busy=0, data_ready=1; no done pulse.
REQ-025 Baseband: accept 0xA5 in mode 00 -> bit_out sequence 1,0,1,0,0,1,0,1, each bit held 64 clk, starting 3 clk after the sym_clk edge; done pulses once, 8 symbol periods after the first bit.
REQ-026 ASK and FSK:
- 0xF0 in mode 01 -> mod_out toggles every 4 clk for 4 symbols, then stays 0 for 4 symbols.
- 0x0F in mode 10 -> half-period 4 for 4 symbols, then half-period 2.
REQ-027 PSK: 0x55 in mode 11 with MOD_SYMBOL_TX_PSK_EN -> mod_out = ~car0 on 1-bits; without the macro -> mod_out equals bit_out.
REQ-028 Handshake: hold data_valid high with 0x3C during a busy transfer -> data_ready=0 throughout and the word is not accepted early; it is accepted the cycle after done.
REQ-029 Edge coincidence: accept a word in the cycle sym_edge pulses -> first bit appears only on the following sym_edge (64 clk later).
